// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU with built-in ALU-control decode, valid/ready handshake and a
// bit-serial shifter that moves one bit per cycle for SLL/SRL/SRA.
//
// state | meaning
// IDLE  | ready for a request; in_ready high unless in reset
// SHIFT | serial shift in progress; count holds the remaining steps
// DONE  | result presented with out_valid; held until out_ready
module alu_ctrl_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         ctrl,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_SLL = 4'b1000;
  localparam logic [3:0] CTRL_SRL = 4'b1001;
  localparam logic [3:0] CTRL_SRA = 4'b1010;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_XOR = 4'b1101;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [SHAMT_W-1:0] count;
  logic [3:0]         op_ctrl;

  logic [3:0]         dec_ctrl;
  logic               dec_shift;
  logic               accept;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               ovf_add;
  logic               ovf_sub;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_ovf;
  logic [WIDTH-1:0]   shift_next;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = CTRL_ILL;
    case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_OR;
      default: begin
        case (funct)
          6'b100000: dec_ctrl = CTRL_ADD;
          6'b100010: dec_ctrl = CTRL_SUB;
          6'b100100: dec_ctrl = CTRL_AND;
          6'b100101: dec_ctrl = CTRL_OR;
          6'b101010: dec_ctrl = CTRL_SLT;
          6'b100111: dec_ctrl = CTRL_NOR;
          6'b100110: dec_ctrl = CTRL_XOR;
          6'b000000: dec_ctrl = CTRL_SLL;
          6'b000010: dec_ctrl = CTRL_SRL;
          6'b000011: dec_ctrl = CTRL_SRA;
          default:   dec_ctrl = CTRL_ILL;
        endcase
      end
    endcase
  end

  assign dec_shift = (dec_ctrl[3:2] == 2'b10);

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Shift codes land here only for shamt==0, where the result is b unchanged.
  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    case (dec_ctrl)
      CTRL_AND: exec_res = a & b;
      CTRL_OR:  exec_res = a | b;
      CTRL_ADD: begin exec_res = sum;  exec_ovf = ovf_add; end
      CTRL_SUB: begin exec_res = diff; exec_ovf = ovf_sub; end
      CTRL_SLT: exec_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      CTRL_NOR: exec_res = ~(a | b);
      CTRL_XOR: exec_res = a ^ b;
      CTRL_SLL, CTRL_SRL, CTRL_SRA: exec_res = b;
      default:  exec_res = '0;
    endcase
  end

  always_comb begin
    shift_next = shift_reg;
    case (op_ctrl)
      CTRL_SLL: shift_next = {shift_reg[WIDTH-2:0], 1'b0};
      CTRL_SRL: shift_next = {1'b0, shift_reg[WIDTH-1:1]};
      CTRL_SRA: shift_next = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
      default:  shift_next = shift_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      op_ctrl   <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      ctrl      <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_shift && (shamt != '0)) begin
              shift_reg <= b;
              count     <= shamt;
              op_ctrl   <= dec_ctrl;
              state     <= SHIFT;
            end else begin
              result    <= exec_res;
              ctrl      <= dec_ctrl;
              zero      <= (exec_res == '0);
              overflow  <= exec_ovf;
              illegal   <= (dec_ctrl == CTRL_ILL);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          // The last step publishes directly so latency is exactly shamt+1.
          shift_reg <= shift_next;
          count     <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            result    <= shift_next;
            ctrl      <= op_ctrl;
            zero      <= (shift_next == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed bench for alu_ctrl_exec: decode, flags, shift latency,
// backpressure, illegal funct and reset during a shift.
module tb_alu_ctrl_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  ctrl;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_ctrl_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ctrl(ctrl), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE (called #1 after a rising edge), scramble the
  // inputs after accept, and return cycles until out_valid (1 = next cycle).
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] sh, output int latency);
    alu_op = op; funct = fn; a = va; b = vb; shamt = sh;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 2'b10; funct = 6'h3F; a = 32'hDEADBEEF; b = 32'h12345678; shamt = 5'd7;
    latency = 1;
    while (!out_valid && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
    if (!out_valid) latency = 999;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 6'h00; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {ctrl, zero, overflow, illegal}, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    run_op(2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 5'd0, lat);
    check("add_lat", lat, 1);
    check("add_res", result, 32'h80000000);
    check("add_flags", {ctrl, zero, overflow, illegal}, {4'b0010, 3'b010});

    // Backpressure: hold DONE, offer a new request that must be ignored.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; alu_op = 2'b00; a = 32'h1; b = 32'h1;
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, result, ctrl}, {1'b1, 32'h80000000, 4'b0010});
    end
    in_valid = 1'b0;
    pop();
    check("pop_valid", out_valid, 0);
    check("pop_result_kept", result, 32'h80000000);

    run_op(2'b01, 6'h00, 32'h1234, 32'h1234, 5'd0, lat);
    check("sub_res", result, 0);
    check("sub_flags", {ctrl, zero, overflow, illegal}, {4'b0110, 3'b100});
    pop();

    run_op(2'b10, 6'b100010, 32'h80000000, 32'h1, 5'd0, lat);
    check("subr_res", result, 32'h7FFFFFFF);
    check("subr_flags", {ctrl, zero, overflow, illegal}, {4'b0110, 3'b010});
    pop();

    run_op(2'b10, 6'b101010, 32'hFFFFFFFB, 32'h3, 5'd0, lat);
    check("slt_neg_res", result, 1);
    check("slt_neg_flags", {ctrl, zero, overflow, illegal}, {4'b0111, 3'b000});
    pop();
    run_op(2'b10, 6'b101010, 32'h3, 32'hFFFFFFFB, 5'd0, lat);
    check("slt_pos_res", result, 0);
    check("slt_pos_flags", {ctrl, zero, overflow, illegal}, {4'b0111, 3'b100});
    pop();

    run_op(2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 5'd0, lat);
    check("and", {ctrl, result}, {4'b0000, 32'h0000F000});
    pop();
    run_op(2'b11, 6'b000000, 32'h0000000F, 32'h000000F0, 5'd0, lat);
    check("ori", {ctrl, result}, {4'b0001, 32'h000000FF});
    pop();
    run_op(2'b10, 6'b100111, 32'h0, 32'h0, 5'd0, lat);
    check("nor", {ctrl, result, zero}, {4'b1100, 32'hFFFFFFFF, 1'b0});
    pop();
    run_op(2'b10, 6'b100110, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, lat);
    check("xor", {ctrl, result}, {4'b1101, 32'hF0F00F0F});
    pop();

    run_op(2'b10, 6'h3F, 32'h5, 32'h7, 5'd0, lat);
    check("ill_lat", lat, 1);
    check("ill_res", result, 0);
    check("ill_flags", {ctrl, zero, overflow, illegal}, {4'b1111, 3'b101});
    pop();

    run_op(2'b10, 6'b000000, 32'hABCD0055, 32'h55, 5'd0, lat);
    check("sll0_lat", lat, 1);
    check("sll0", {ctrl, result}, {4'b1000, 32'h00000055});
    pop();
    run_op(2'b10, 6'b000000, 32'h0, 32'h1, 5'd4, lat);
    check("sll4_lat", lat, 5);
    check("sll4", {ctrl, result, zero, overflow, illegal}, {4'b1000, 32'h10, 3'b000});
    pop();
    run_op(2'b10, 6'b000011, 32'h0, 32'h80000000, 5'd31, lat);
    check("sra31_lat", lat, 32);
    check("sra31", {ctrl, result}, {4'b1010, 32'hFFFFFFFF});
    pop();
    run_op(2'b10, 6'b000010, 32'h0, 32'h80000000, 5'd31, lat);
    check("srl31_lat", lat, 32);
    check("srl31", {ctrl, result}, {4'b1001, 32'h00000001});
    pop();

    // Reset in the middle of a long shift.
    alu_op = 2'b10; funct = 6'b000000; b = 32'h3; shamt = 5'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("shift_busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {result, ctrl, zero, overflow, illegal}, 0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    seen_valid = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_late_valid", seen_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
